stream_upsizer: RTL and testbench

Valid/ready stream width converter. It gathers Ratio consecutive narrow beats of DataWidth bits into one wide word of DataWidth*Ratio bits. It is the receive/gather counterpart to the team's narrow-beat stream producers and sits between a narrow serial-ish source and a wide datapath consumer. The block sustains full throughput of one narrow beat per cycle and has a registered wide output.

---
 rtl/stream_upsizer.sv | 132 +++++++++++++
 tb/tb_stream_upsizer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_upsizer.sv
// stream_upsizer: packs Ratio narrow valid/ready beats into one wide word.
// Little-endian lane order; the wide word and its valid come from registers.
//
// Parameters:
//   DataWidth - bits per narrow input beat (>=1)
//   Ratio     - narrow beats per wide output word (>=1)
//
// Ports:
//   clk_i            - clock, rising edge
//   srst_i           - synchronous reset, active-high
//   data_in_i        - narrow input beat
//   data_in_valid_i  - input beat valid
//   data_in_ready_o  - input beat can be accepted
//   data_out_o       - packed wide word (lane 0 = first beat)
//   data_out_valid_o - wide word valid
//   data_out_ready_i - downstream accepts wide word
//
// Optional build macro STREAM_UPSIZER_LAST_EN:
//   data_in_last_i   - closes a word early, at any lane
//   data_out_keep_o  - one bit per lane, set for filled lanes
module stream_upsizer #(
  parameter int DataWidth = 8,
  parameter int Ratio     = 4
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic [DataWidth-1:0]       data_in_i,
  input  logic                       data_in_valid_i,
`ifdef STREAM_UPSIZER_LAST_EN
  input  logic                       data_in_last_i,
  output logic [Ratio-1:0]           data_out_keep_o,
`endif
  output logic                       data_in_ready_o,
  output logic [DataWidth*Ratio-1:0] data_out_o,
  output logic                       data_out_valid_o,
  input  logic                       data_out_ready_i
);

  localparam int CntW  = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam int WordW = DataWidth * Ratio;
  localparam logic [CntW-1:0] CntMax = CntW'(Ratio - 1);

  logic [CntW-1:0]  cnt;
  logic [WordW-1:0] acc;
  logic [WordW-1:0] out_q;
  logic             out_valid;

  logic [WordW-1:0] word_nxt;
  logic             last;
  logic             final_beat;
  logic             in_fire;
  logic             out_fire;

`ifdef STREAM_UPSIZER_LAST_EN
  assign last = data_in_last_i;
`else
  assign last = 1'b0;
`endif

  // A closing beat needs the output register to be free
  // (or being drained this very cycle).
  assign final_beat = (cnt == CntMax) | last;

  assign data_in_ready_o =
    final_beat ? (!out_valid | data_out_ready_i) : 1'b1;

  assign in_fire  = data_in_valid_i & data_in_ready_o;
  assign out_fire = out_valid & data_out_ready_i;

  assign data_out_o       = out_q;
  assign data_out_valid_o = out_valid;

  // Lanes below cnt come from acc, lane cnt is the
  // current beat, lanes above stay zero (early close).
  always_comb begin
    word_nxt = '0;
    for (int k = 0; k < Ratio; k++) begin
      if (CntW'(k) < cnt) begin
        word_nxt[k*DataWidth +: DataWidth] =
          acc[k*DataWidth +: DataWidth];
      end else if (CntW'(k) == cnt) begin
        word_nxt[k*DataWidth +: DataWidth] = data_in_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt       <= '0;
      acc       <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_fire) begin
        out_valid <= 1'b0;
      end
      // A closing beat in the same cycle as an output fire
      // overrides the clear above, so there is no bubble.
      if (in_fire) begin
        if (final_beat) begin
          out_q     <= word_nxt;
          out_valid <= 1'b1;
          cnt       <= '0;
        end else begin
          for (int k = 0; k < Ratio; k++) begin
            if (CntW'(k) == cnt) begin
              acc[k*DataWidth +: DataWidth] <= data_in_i;
            end
          end
          cnt <= cnt + CntW'(1);
        end
      end
    end
  end

`ifdef STREAM_UPSIZER_LAST_EN
  logic [Ratio-1:0] keep_q;

  assign data_out_keep_o = keep_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      keep_q <= '0;
    end else if (in_fire && final_beat) begin
      for (int k = 0; k < Ratio; k++) begin
        keep_q[k] <= (CntW'(k) <= cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_upsizer.sv
// tb_stream_upsizer: directed and random checks of stream_upsizer.
// DataWidth=8, Ratio=4.
module tb_stream_upsizer;

  localparam int DW = 8;
  localparam int R  = 4;

  logic          clk = 1'b0;
  logic          srst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_last;
  logic          din_ready;
  logic [DW*R-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [R-1:0]  dout_keep;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_upsizer #(
    .DataWidth(DW),
    .Ratio(R)
  ) dut (
    .clk_i(clk),
    .srst_i(srst),
    .data_in_i(din),
    .data_in_valid_i(din_valid),
`ifdef STREAM_UPSIZER_LAST_EN
    .data_in_last_i(din_last),
    .data_out_keep_o(dout_keep),
`endif
    .data_in_ready_o(din_ready),
    .data_out_o(dout),
    .data_out_valid_o(dout_valid),
    .data_out_ready_i(dout_ready)
  );

`ifndef STREAM_UPSIZER_LAST_EN
  assign dout_keep = '1;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst       = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    din_last   = 1'b0;
    dout_ready = 1'b0;
    step();
    step();
    srst = 1'b0;
  endtask

  task automatic test_reset();
    srst       = 1'b1;
    din        = 8'hFF;
    din_valid  = 1'b1;
    din_last   = 1'b0;
    dout_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid: got %b want 0", dout_valid);
      end
      checks++;
      if (dout !== '0) begin
        errors++;
        $display("FAIL reset_data: got %h want 0", dout);
      end
      checks++;
      if (din_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready: got %b want 1", din_ready);
      end
    end
    srst      = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] b [4];
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din       = b[i];
      din_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (din_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_ready%0d: got %b want 1", i, din_ready);
      end
      checks++;
      if (dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_early%0d: got %b want 0", i, dout_valid);
      end
      step();
    end
    din_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 32'h44332211) begin
      errors++;
      $display("FAIL basic_word: got v=%b %h want v=1 44332211",
               dout_valid, dout);
    end
    step();
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: got v=%b want 0", dout_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    dout_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      din       = 8'(i);
      din_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (din_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_accept%0d: got %b want 1", i, din_ready);
      end
      step();
    end
    din = 8'h08;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (din_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: got %b want 0", j, din_ready);
      end
      checks++;
      if (dout_valid !== 1'b1 || dout !== 32'h04030201) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b %h want v=1 04030201",
                 j, dout_valid, dout);
      end
      if (j < 2) step();
    end
    dout_ready = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got %b want 1", din_ready);
    end
    step();
    din_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 32'h08070605) begin
      errors++;
      $display("FAIL bp_word2: got v=%b %h want v=1 08070605",
               dout_valid, dout);
    end
    step();
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got v=%b want 0", dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic       exp_v;
    logic [31:0] exp_w;
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      din       = 8'(i);
      din_valid = (i < 12);
      @(negedge clk);
      if (i < 12) begin
        checks++;
        if (din_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready%0d: got %b want 1", i, din_ready);
        end
      end
      exp_v = (i >= 4) && (i % 4 == 0);
      checks++;
      if (dout_valid !== exp_v) begin
        errors++;
        $display("FAIL b2b_valid%0d: got %b want %b",
                 i, dout_valid, exp_v);
      end
      if (exp_v) begin
        exp_w = {8'(i-1), 8'(i-2), 8'(i-3), 8'(i-4)};
        checks++;
        if (dout !== exp_w) begin
          errors++;
          $display("FAIL b2b_word%0d: got %h want %h", i, dout, exp_w);
        end
      end
      step();
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset_midfill();
    logic [7:0] b [6];
    logic [7:0] a [4];
    b = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hAA, 8'hBB};
    a = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din       = b[i];
      din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 32'hC3C2C1C0) begin
      errors++;
      $display("FAIL mid_pending: got v=%b %h want v=1 c3c2c1c0",
               dout_valid, dout);
    end
    srst = 1'b1;
    step();
    checks++;
    if (dout_valid !== 1'b0 || dout !== '0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got v=%b d=%h r=%b want v=0 d=0 r=1",
               dout_valid, dout, din_ready);
    end
    srst       = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din       = a[i];
      din_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale%0d: got v=%b d=%h want v=0",
                 i, dout_valid, dout);
      end
      step();
    end
    din_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 32'hA3A2A1A0) begin
      errors++;
      $display("FAIL mid_word: got v=%b %h want v=1 a3a2a1a0",
               dout_valid, dout);
    end
    step();
  endtask

  task automatic test_random();
    logic [7:0]  beatq [$];
    logic [31:0] expq [$];
    logic [31:0] w;
    logic [31:0] prev_word;
    logic        prev_stall;
    int          accepted;
    int          cyc;
    int          words;
    do_reset();
    accepted   = 0;
    cyc        = 0;
    words      = 0;
    prev_stall = 1'b0;
    prev_word  = '0;
    while ((accepted < 1000 || expq.size() != 0) && cyc < 20000) begin
      if (accepted < 1000) begin
        din_valid  = 1'($urandom_range(0, 1));
        din        = 8'($urandom);
        dout_ready = 1'($urandom_range(0, 1));
      end else begin
        din_valid  = 1'b0;
        dout_ready = 1'b1;
      end
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (dout_valid !== 1'b1 || dout !== prev_word) begin
          errors++;
          $display("FAIL rnd_stable c%0d: got v=%b %h want v=1 %h",
                   cyc, dout_valid, dout, prev_word);
        end
      end
      if (dout_valid && dout_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra c%0d: got %h want none", cyc, dout);
        end else begin
          w = expq.pop_front();
          words++;
          if (dout !== w) begin
            errors++;
            $display("FAIL rnd_word c%0d: got %h want %h", cyc, dout, w);
          end
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_word  = dout;
      if (din_valid && din_ready) begin
        beatq.push_back(din);
        accepted++;
        if (beatq.size() == 4) begin
          expq.push_back({beatq[3], beatq[2], beatq[1], beatq[0]});
          beatq.delete();
        end
      end
      cyc++;
      step();
    end
    checks++;
    if (cyc >= 20000) begin
      errors++;
      $display("FAIL rnd_timeout: got %0d beats want 1000", accepted);
    end
    checks++;
    if (words != 250) begin
      errors++;
      $display("FAIL rnd_count: got %0d words want 250", words);
    end
    din_valid = 1'b0;
  endtask

`ifdef STREAM_UPSIZER_LAST_EN
  task automatic test_last();
    do_reset();
    dout_ready = 1'b1;
    din_valid  = 1'b1;
    din        = 8'h55;
    din_last   = 1'b0;
    step();
    din        = 8'h66;
    din_last   = 1'b1;
    step();
    din_valid = 1'b0;
    din_last  = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 32'h00006655 ||
        dout_keep !== 4'b0011) begin
      errors++;
      $display("FAIL last_short: got v=%b %h k=%b want v=1 00006655 k=0011",
               dout_valid, dout, dout_keep);
    end
    for (int i = 1; i <= 4; i++) begin
      din       = 8'(i);
      din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 32'h04030201 ||
        dout_keep !== 4'b1111) begin
      errors++;
      $display("FAIL last_full: got v=%b %h k=%b want v=1 04030201 k=1111",
               dout_valid, dout, dout_keep);
    end
    step();
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    srst       = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    din_last   = 1'b0;
    dout_ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_midfill();
    test_random();
`ifdef STREAM_UPSIZER_LAST_EN
    test_last();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
